// File: rtl/rc4_phase_ctrl_if.sv
// Phase handshakes, client S-memory requests and the shared S-memory port of the
// RC4 phase sequencer.
interface rc4_phase_ctrl_if;
  // *_start are single-cycle pulses from the sequencer. *_finish is sampled only
  // while the matching phase is waiting; level or pulse both work. prga_bad is read
  // only in the cycle prga_finish is accepted.
  logic       init_start;
  logic       ksa_start;
  logic       prga_start;
  logic       init_finish;
  logic       ksa_finish;
  logic       prga_finish;
  logic       prga_bad;
  logic [7:0] init_addr;
  logic [7:0] init_data;
  logic       init_wen;
  logic [7:0] ksa_addr;
  logic [7:0] ksa_data;
  logic       ksa_wen;
  logic [7:0] prga_addr;
  logic [7:0] prga_data;
  logic       prga_wen;
  logic [7:0] s_addr;
  logic [7:0] s_data;
  logic       s_wen;

  modport master (
    output init_start, ksa_start, prga_start, s_addr, s_data, s_wen,
    input  init_finish, ksa_finish, prga_finish, prga_bad,
    input  init_addr, init_data, init_wen,
    input  ksa_addr, ksa_data, ksa_wen,
    input  prga_addr, prga_data, prga_wen
  );

  modport slave (
    input  init_start, ksa_start, prga_start, s_addr, s_data, s_wen,
    output init_finish, ksa_finish, prga_finish, prga_bad,
    output init_addr, init_data, init_wen,
    output ksa_addr, ksa_data, ksa_wen,
    output prga_addr, prga_data, prga_wen
  );
endinterface

// File: rtl/rc4_phase_ctrl.sv
// Sequencer for one RC4 decryption run: init -> KSA -> PRGA per key, walking the key
// range on bad plaintext, and sole owner of the shared S-memory port.
module rc4_phase_ctrl #(
  parameter int                KEY_W     = 24,
  parameter logic [KEY_W-1:0]  KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0]  KEY_MAX   = 24'h3FFFFF,
  parameter int                TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  rc4_phase_ctrl_if.master     bus,
  output logic [1:0]           sel,
  output logic [KEY_W-1:0]     key,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic                 err_timeout,
  output logic [3:0]           state_dbg
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_INIT = 2'b01;
  localparam logic [1:0] SEL_KSA  = 2'b10;
  localparam logic [1:0] SEL_PRGA = 2'b11;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT_GO   = 4'd1,
    INIT_WAIT = 4'd2,
    KSA_GO    = 4'd3,
    KSA_WAIT  = 4'd4,
    PRGA_GO   = 4'd5,
    PRGA_WAIT = 4'd6,
    NEXT_KEY  = 4'd7,
    DONE      = 4'd8,
    FAIL      = 4'd9
  } state_t;

  state_t        state;
  logic          in_wait;
  logic [CW-1:0] wd_cnt;
  logic          wd_expired;

  assign state_dbg  = state;
  assign wd_expired = (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      key             <= KEY_START;
      sel             <= SEL_NONE;
      in_wait         <= 1'b0;
      wd_cnt          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      fail            <= 1'b0;
      err_timeout     <= 1'b0;
      bus.init_start  <= 1'b0;
      bus.ksa_start   <= 1'b0;
      bus.prga_start  <= 1'b0;
    end else begin
      bus.init_start <= 1'b0;
      bus.ksa_start  <= 1'b0;
      bus.prga_start <= 1'b0;
      case (state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            state          <= INIT_GO;
            key            <= KEY_START;
            done           <= 1'b0;
            fail           <= 1'b0;
            err_timeout    <= 1'b0;
            busy           <= 1'b1;
            sel            <= SEL_INIT;
            bus.init_start <= 1'b1;
          end
        end
        INIT_GO: begin
          state   <= INIT_WAIT;
          in_wait <= 1'b1;
          wd_cnt  <= '0;
        end
        INIT_WAIT: begin
          // A finish on the expiry cycle still advances the run.
          if (bus.init_finish) begin
            state         <= KSA_GO;
            sel           <= SEL_KSA;
            in_wait       <= 1'b0;
            bus.ksa_start <= 1'b1;
          end else if (wd_expired) begin
            state       <= FAIL;
            sel         <= SEL_NONE;
            in_wait     <= 1'b0;
            busy        <= 1'b0;
            fail        <= 1'b1;
            err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        KSA_GO: begin
          state   <= KSA_WAIT;
          in_wait <= 1'b1;
          wd_cnt  <= '0;
        end
        KSA_WAIT: begin
          if (bus.ksa_finish) begin
            state          <= PRGA_GO;
            sel            <= SEL_PRGA;
            in_wait        <= 1'b0;
            bus.prga_start <= 1'b1;
          end else if (wd_expired) begin
            state       <= FAIL;
            sel         <= SEL_NONE;
            in_wait     <= 1'b0;
            busy        <= 1'b0;
            fail        <= 1'b1;
            err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        PRGA_GO: begin
          state   <= PRGA_WAIT;
          in_wait <= 1'b1;
          wd_cnt  <= '0;
        end
        PRGA_WAIT: begin
          if (bus.prga_finish) begin
            sel     <= SEL_NONE;
            in_wait <= 1'b0;
            if (!bus.prga_bad) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (key == KEY_MAX) begin
              state <= FAIL;
              busy  <= 1'b0;
              fail  <= 1'b1;
            end else begin
              state <= NEXT_KEY;
            end
          end else if (wd_expired) begin
            state       <= FAIL;
            sel         <= SEL_NONE;
            in_wait     <= 1'b0;
            busy        <= 1'b0;
            fail        <= 1'b1;
            err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        NEXT_KEY: begin
          // Every key restarts from a freshly initialised S-memory.
          state          <= INIT_GO;
          key            <= key + KEY_W'(1);
          sel            <= SEL_INIT;
          bus.init_start <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          sel     <= SEL_NONE;
          in_wait <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Writes pass only while the owning phase is waiting; GO cycles never write.
  always_comb begin
    bus.s_addr = 8'h00;
    bus.s_data = 8'h00;
    bus.s_wen  = 1'b0;
    case (sel)
      SEL_INIT: begin
        bus.s_addr = bus.init_addr;
        bus.s_data = bus.init_data;
        bus.s_wen  = in_wait & bus.init_wen;
      end
      SEL_KSA: begin
        bus.s_addr = bus.ksa_addr;
        bus.s_data = bus.ksa_data;
        bus.s_wen  = in_wait & bus.ksa_wen;
      end
      SEL_PRGA: begin
        bus.s_addr = bus.prga_addr;
        bus.s_data = bus.prga_data;
        bus.s_wen  = in_wait & bus.prga_wen;
      end
      default: begin
        bus.s_addr = 8'h00;
        bus.s_data = 8'h00;
        bus.s_wen  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_phase_ctrl.sv
// Bench for rc4_phase_ctrl: stub phase blocks, directed runs with hand-computed
// event timelines, and a monitor that checks every observed event against them.
module tb_rc4_phase_ctrl;

  localparam int          KEY_W = 24;
  localparam logic [23:0] KS    = 24'h000010;
  localparam logic [23:0] KM    = 24'h000012;
  localparam int          TO    = 16;
  localparam int          W     = 71;

  localparam logic [3:0] K_RST = 4'd0;
  localparam logic [3:0] K_IS  = 4'd1;
  localparam logic [3:0] K_IW  = 4'd2;
  localparam logic [3:0] K_KS  = 4'd3;
  localparam logic [3:0] K_KW  = 4'd4;
  localparam logic [3:0] K_PS  = 4'd5;
  localparam logic [3:0] K_PW  = 4'd6;
  localparam logic [3:0] K_DN  = 4'd8;
  localparam logic [3:0] K_FL  = 4'd9;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       sel;
  logic [KEY_W-1:0] key;
  logic             busy, done, fail, err_timeout;
  logic [3:0]       state_dbg;

  rc4_phase_ctrl_if bus ();

  rc4_phase_ctrl #(
    .KEY_W(KEY_W), .KEY_START(KS), .KEY_MAX(KM), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .sel(sel), .key(key), .busy(busy), .done(done), .fail(fail),
    .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  logic        rst_seen = 1'b0;
  logic        ksa_hang;
  logic [23:0] bad_until;
  int          vectors = 0;
  int          miscompares = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  // event word: kind, state, sel, s_wen, s_addr, s_data, key, {busy,done,fail,err}, cycle
  function automatic logic [W-1:0] mk(input logic [3:0] kind, input logic [3:0] st,
                                      input logic [1:0] s, input logic wen,
                                      input logic [7:0] a, input logic [7:0] d,
                                      input logic [23:0] k, input logic [3:0] fl,
                                      input int c);
    return {kind, st, s, wen, a, d, k, fl, 16'(c)};
  endfunction

  // stub phase blocks: finish pulses 3 cycles after each start pulse
  initial begin
    bus.init_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.init_start === 1'b1) begin
        repeat (3) @(posedge clk);
        #1 bus.init_finish = 1'b1;
        @(posedge clk);
        #1 bus.init_finish = 1'b0;
      end
    end
  end

  initial begin
    bus.ksa_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ksa_start === 1'b1 && !ksa_hang) begin
        repeat (3) @(posedge clk);
        #1 bus.ksa_finish = 1'b1;
        @(posedge clk);
        #1 bus.ksa_finish = 1'b0;
      end
    end
  end

  initial begin
    bus.prga_finish = 1'b0;
    bus.prga_bad    = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.prga_start === 1'b1) begin
        repeat (3) @(posedge clk);
        #1 bus.prga_bad = (key < bad_until);
        bus.prga_finish = 1'b1;
        @(posedge clk);
        #1 bus.prga_finish = 1'b0;
        bus.prga_bad    = 1'b0;
      end
    end
  end

  // monitor
  logic prev_is = 1'b0, prev_ks = 1'b0, prev_ps = 1'b0, prev_done = 1'b0, prev_fail = 1'b0;
  always @(negedge clk) begin
    logic [3:0]   kind;
    logic         hit;
    logic [W-1:0] got, exp_v;
    hit  = 1'b1;
    kind = K_RST;
    if (rst_seen)                  kind = K_RST;
    else if (bus.init_start)       kind = K_IS;
    else if (bus.ksa_start)        kind = K_KS;
    else if (bus.prga_start)       kind = K_PS;
    else if (prev_is)              kind = K_IW;
    else if (prev_ks)              kind = K_KW;
    else if (prev_ps)              kind = K_PW;
    else if (done && !prev_done)   kind = K_DN;
    else if (fail && !prev_fail)   kind = K_FL;
    else                           hit = 1'b0;
    if (hit) begin
      got = mk(kind, state_dbg, sel, bus.s_wen, bus.s_addr, bus.s_data, key,
               {busy, done, fail, err_timeout}, cyc);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got %h, required none (cycle %0d)", got, cyc);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          miscompares++;
          $display("FAIL event_kind%0d: got %h, required %h (cycle %0d)", kind, got, exp_v, cyc);
        end
      end
    end
    prev_is   = (bus.init_start === 1'b1) && !rst_seen;
    prev_ks   = (bus.ksa_start === 1'b1) && !rst_seen;
    prev_ps   = (bus.prga_start === 1'b1) && !rst_seen;
    prev_done = (done === 1'b1);
    prev_fail = (fail === 1'b1);
  end

  logic [7:0] ia, id, ka, kd, pa, pd;

  task automatic set_clients(input logic [7:0] a0, d0, a1, d1, a2, d2);
    ia = a0; id = d0; ka = a1; kd = d1; pa = a2; pd = d2;
    bus.init_addr = a0; bus.init_data = d0; bus.init_wen = 1'b1;
    bus.ksa_addr  = a1; bus.ksa_data  = d1; bus.ksa_wen  = 1'b1;
    bus.prga_addr = a2; bus.prga_data = d2; bus.prga_wen = 1'b1;
  endtask

  // GO cycle at p+1/+5/+9 with s_wen held low, WAIT cycle right after with s_wen=1
  task automatic push_pass(input int p, input logic [23:0] k, input int phases);
    exp_q.push_back(mk(K_IS, 4'd1, 2'b01, 1'b0, ia, id, k, 4'b1000, p + 1));
    exp_q.push_back(mk(K_IW, 4'd2, 2'b01, 1'b1, ia, id, k, 4'b1000, p + 2));
    exp_q.push_back(mk(K_KS, 4'd3, 2'b10, 1'b0, ka, kd, k, 4'b1000, p + 5));
    exp_q.push_back(mk(K_KW, 4'd4, 2'b10, 1'b1, ka, kd, k, 4'b1000, p + 6));
    if (phases > 2) begin
      exp_q.push_back(mk(K_PS, 4'd5, 2'b11, 1'b0, pa, pd, k, 4'b1000, p + 9));
      exp_q.push_back(mk(K_PW, 4'd6, 2'b11, 1'b1, pa, pd, k, 4'b1000, p + 10));
    end
  endtask

  task automatic pulse_start(output int p);
    @(posedge clk);
    #1;
    p     = cyc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < c);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d expected events still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (6) @(posedge clk);
  endtask

  initial begin
    int p;
    reset     = 1'b1;
    start     = 1'b0;
    ksa_hang  = 1'b0;
    bad_until = KS;
    set_clients(8'h11, 8'hA1, 8'h22, 8'hA2, 8'h33, 8'hA3);
    for (int c = 1; c <= 3; c++)
      exp_q.push_back(mk(K_RST, 4'd0, 2'b00, 1'b0, 8'h00, 8'h00, KS, 4'b0000, c));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_drain(10);

    // 1: clean run, first key good
    pulse_start(p);
    push_pass(p, KS, 3);
    exp_q.push_back(mk(K_DN, 4'd8, 2'b00, 1'b0, 8'h00, 8'h00, KS, 4'b0100, p + 13));
    wait_drain(100);

    // 2: two bad keys then good; done flag from run 1 clears on start
    bad_until = KS + 24'd2;
    pulse_start(p);
    for (int n = 0; n < 3; n++) push_pass(p + 13 * n, KS + 24'(n), 3);
    exp_q.push_back(mk(K_DN, 4'd8, 2'b00, 1'b0, 8'h00, 8'h00, KS + 24'd2, 4'b0100, p + 39));
    wait_drain(200);

    // 3: every key bad -> range exhausted at KEY_MAX
    bad_until = 24'hFFFFFF;
    pulse_start(p);
    for (int n = 0; n < 3; n++) push_pass(p + 13 * n, KS + 24'(n), 3);
    exp_q.push_back(mk(K_FL, 4'd9, 2'b00, 1'b0, 8'h00, 8'h00, KM, 4'b0010, p + 39));
    wait_drain(200);

    // 4: KSA never finishes -> watchdog fail 16 cycles after KSA_WAIT entry (p+6)
    bad_until = KS;
    ksa_hang  = 1'b1;
    pulse_start(p);
    push_pass(p, KS, 2);
    exp_q.push_back(mk(K_FL, 4'd9, 2'b00, 1'b0, 8'h00, 8'h00, KS, 4'b0011, p + 22));
    wait_drain(100);
    ksa_hang = 1'b0;

    // 5: new client addresses, start pulsed in KSA_WAIT has no effect
    set_clients(8'h3C, 8'h5A, 8'hC3, 8'hA5, 8'h7E, 8'h81);
    pulse_start(p);
    push_pass(p, KS, 3);
    exp_q.push_back(mk(K_DN, 4'd8, 2'b00, 1'b0, 8'h00, 8'h00, KS, 4'b0100, p + 13));
    wait_cyc(p + 7);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain(100);

    // 6: reset during second-key PRGA_WAIT, then a normal run
    bad_until = KS + 24'd1;
    pulse_start(p);
    push_pass(p, KS, 3);
    push_pass(p + 13, KS + 24'd1, 3);
    exp_q.push_back(mk(K_RST, 4'd0, 2'b00, 1'b0, 8'h00, 8'h00, KS, 4'b0000, p + 25));
    wait_cyc(p + 24);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    wait_drain(100);

    bad_until = KS;
    pulse_start(p);
    push_pass(p, KS, 3);
    exp_q.push_back(mk(K_DN, 4'd8, 2'b00, 1'b0, 8'h00, 8'h00, KS, 4'b0100, p + 13));
    wait_drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
